core_reset_seq: RTL and testbench
=================================

Name: core_reset_seq

Overview:
- Parametrised reset sequencer that replaces the ad-hoc reset counter and post-download delayed reset logic in console top levels.
- Merges N maskable reset request sources (OSD reset, button, download, spare) into one stretched core reset of programmable length.
- Adds an optional delayed "second reset" after a ROM download, cancellable per download.
- Optionally records the reset cause and a reset count for debug LEDs/OSD.
- Sits between user_io/data_io and the console core, in the clk_sys domain.

Parameters:
- NUM_SRC, 4, number of request inputs (1..8).
- HOLD_CYCLES, 1000, length of the core_reset pulse in clk_sys cycles (>=1).
- CNT_W, 16, hold counter width; must satisfy HOLD_CYCLES < 2**CNT_W.
- DELAY_CYCLES, 5000000, cycles from download end to delayed reset (>=2).
- DLY_W, 23, delay timer width; must satisfy DELAY_CYCLES < 2**DLY_W.
- POR_PULSE, 1, when 1 a full hold pulse is issued after module reset releases.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high module reset.
- req  in  NUM_SRC  level reset requests, one per source.
- req_mask  in  NUM_SRC  1 = ignore that source.
- download  in  1  ROM download active (ioctl_download).
- delay_en  in  1  arm the delayed reset while download is high.
- core_reset  out  1  stretched reset to the console core, registered.
- delay_pending  out  1  delayed-reset timer running.
- last_cause  out  NUM_SRC+1  sources that triggered the latest pulse; bit NUM_SRC = delayed reset.
- reset_count  out  8  saturating count of core_reset pulses.

Behaviour:
- Module reset (reset=1): all registers clear. core_reset=0, delay_pending=0, last_cause=0, reset_count=0, timers=0.
  - If POR_PULSE=1, a por flag is set. The cycle after reset falls, por acts as a one-cycle internal request; its cause bit is not recorded.
- Request stage: act = (req & ~req_mask), plus a delayed_fire bit. req_q <= |act | por | delayed_fire.
- Hold counter:
  - If req_q, cnt <= HOLD_CYCLES.
  - Else if cnt != 0, cnt <= cnt-1.
  - core_reset <= (cnt != 0).
- Latency: a one-cycle request sampled at edge k gives core_reset=1 from edge k+2 for exactly HOLD_CYCLES cycles.
  - A level request held for L cycles gives core_reset high for L+HOLD_CYCLES-1 cycles.
- Retrigger: a request during a pulse reloads cnt, so the pulse extends; core_reset never drops in between.
- Cause latch:
  - On any edge where req_q rises from 0, last_cause <= the registered act/delayed_fire vector.
  - While req_q stays high, new bits are OR-ed in.
- reset_count increments on each 0->1 edge of core_reset and saturates at 255.
- Delayed reset timer:
  - While download=1 and delay_en=1: dly <= DELAY_CYCLES.
  - Else if dly != 0: dly <= dly-1.
  - delayed_fire is a one-cycle pulse when dly==1 (it feeds req_q).
  - delay_pending = (dly != 0).
- Cancel: if delay_en=0 while download=1, dly <= 0 (pending delay cancelled).
- Delay clamp: once download=0, a delay_en change has no effect on a running countdown.
- A new download while the countdown runs reloads dly to DELAY_CYCLES.
- Simultaneous events: a request and delayed_fire in the same cycle give one merged pulse, with both cause bits set.
- Reset mid-pulse: core_reset drops the cycle after reset is sampled. With POR_PULSE=1 a fresh full pulse follows.

Optional Feature:
- Macro: CORE_RESET_SEQ_STATS_EN.
- Defined: last_cause and reset_count behave as above.
- Undefined: both outputs are constant 0, and the cause/count registers are not synthesised.
- core_reset timing is identical either way.

Test Plan:
- HOLD_CYCLES=8, POR_PULSE=1: release reset at edge 0 -> core_reset high edges 2..9 exactly; reset_count=1, last_cause=0.
- req[1] one-cycle pulse at edge 20, mask=0 -> core_reset edges 22..29; last_cause=5'b00010; reset_count=2.
- req[0] at edge 40 and req[2] at edge 45 -> single pulse edges 42..54 with no gap; last_cause=5'b00101; reset_count=3.
- req_mask=4'b0100, req[2] held 20 cycles -> core_reset stays 0; counters unchanged.
- DELAY_CYCLES=20, download 1 for 5 cycles with delay_en=1, req[3]=download unmasked -> first pulse from download; delay_pending high; delayed_fire 19 cycles after download falls, giving a second 8-cycle pulse with last_cause bit4=1.
- Same as previous but delay_en dropped while download=1 -> delay_pending=0, no second pulse; then reset asserted mid-pulse -> core_reset 0 next cycle, all stats 0.

Source files
------------

// File: rtl/core_reset_seq.sv
// core_reset_seq: merges maskable reset requests into one stretched core reset, plus optional post-download delayed reset.
// Latency: request sampled at edge k drives core_reset from edge k+2 for HOLD_CYCLES cycles (extended by retriggers).
// Backpressure: none; requests are level inputs and are never dropped. Stats outputs exist only with CORE_RESET_SEQ_STATS_EN.
module core_reset_seq #(
   parameter int NUM_SRC      = 4,
   parameter int HOLD_CYCLES  = 1000,
   parameter int CNT_W        = 16,
   parameter int DELAY_CYCLES = 5000000,
   parameter int DLY_W        = 23,
   parameter int POR_PULSE    = 1
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] req,
   input  logic [NUM_SRC-1:0] req_mask,
   input  logic               download,
   input  logic               delay_en,
   output logic               core_reset,
   output logic               delay_pending,
   output logic [NUM_SRC:0]   last_cause,
   output logic [7:0]         reset_count
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
   localparam logic [DLY_W-1:0] DLY_LOAD  = DLY_W'(DELAY_CYCLES);

   logic [NUM_SRC-1:0] act;
   logic               delayed_fire;
   logic               por;
   logic               req_q;
   logic [CNT_W-1:0]   cnt;
   logic [DLY_W-1:0]   dly;

   // Unmasked sources that are currently requesting a reset.
   assign act = req & ~req_mask;

   // The delayed reset fires on the last count. An active download owns the
   // timer (reload or cancel), so the fire is suppressed while it is high.
   assign delayed_fire  = (dly == DLY_W'(1)) & ~download;
   assign delay_pending = (dly != '0);

   // Request stage: merge all sources plus the one-shot power-on request.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         por   <= (POR_PULSE != 0);
         req_q <= 1'b0;
      end else begin
         por   <= 1'b0;
         req_q <= (|act) | por | delayed_fire;
      end
   end

   // Hold counter: any request reloads the full length, so pulses stretch without gaps.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt        <= '0;
         core_reset <= 1'b0;
      end else begin
         if (req_q) begin
            cnt <= HOLD_LOAD;
         end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         core_reset <= (cnt != '0);
      end
   end

   // Delay timer: armed during download, cancelled by dropping delay_en mid-download,
   // and free-running (immune to delay_en) once the download has ended.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dly <= '0;
      end else if (download) begin
         dly <= delay_en ? DLY_LOAD : '0;
      end else if (dly != '0) begin
         dly <= dly - DLY_W'(1);
      end
   end

`ifdef CORE_RESET_SEQ_STATS_EN
   logic [NUM_SRC:0] cause_q;
   logic [NUM_SRC:0] cause_r;
   logic [7:0]       count_r;

   // Cause snapshot aligned with req_q; the power-on request has no cause bit.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cause_q <= '0;
      end else begin
         cause_q <= {delayed_fire, act};
      end
   end

   // Cause latch: a request starting a new pulse (counter idle) replaces the
   // record; requests that land while the pulse is running are accumulated.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cause_r <= '0;
      end else if (req_q) begin
         if (cnt == '0) begin
            cause_r <= cause_q;
         end else begin
            cause_r <= cause_r | cause_q;
         end
      end
   end

   // Pulse counter: bumps on the edge where core_reset goes 0->1, saturating at 255.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         count_r <= '0;
      end else if ((cnt != '0) && !core_reset && (count_r != 8'hFF)) begin
         count_r <= count_r + 8'd1;
      end
   end

   assign last_cause  = cause_r;
   assign reset_count = count_r;
`else
   assign last_cause  = '0;
   assign reset_count = '0;
`endif

endmodule

// File: tb/tb_core_reset_seq.sv
// Bench for core_reset_seq with HOLD_CYCLES=8, DELAY_CYCLES=20, POR_PULSE=1.
// Each vector runs a fixed window of cycles from idle and records pulse start/length and delay_pending time.
// Expected stats follow CORE_RESET_SEQ_STATS_EN: real values when defined, zero otherwise.
module tb_core_reset_seq;

   localparam int NS  = 4;
   localparam int RUN = 60;
`ifdef CORE_RESET_SEQ_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk_sys = 1'b0;
   logic          reset;
   logic [NS-1:0] req;
   logic [NS-1:0] req_mask;
   logic          download;
   logic          delay_en;
   logic          core_reset;
   logic          delay_pending;
   logic [NS:0]   last_cause;
   logic [7:0]    reset_count;

   int errors = 0;
   int checks = 0;
   int exp_count = 0;

   core_reset_seq #(
      .NUM_SRC(NS), .HOLD_CYCLES(8), .CNT_W(4),
      .DELAY_CYCLES(20), .DLY_W(6), .POR_PULSE(1)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .req(req), .req_mask(req_mask),
      .download(download), .delay_en(delay_en), .core_reset(core_reset),
      .delay_pending(delay_pending), .last_cause(last_cause), .reset_count(reset_count)
   );

   always #5 clk_sys = ~clk_sys;

   // Stimulus: req_a for len_a cycles from 0, req_b for len_b cycles from off_b,
   // download for dl_len cycles, delay_en for den_len cycles. Expected: first/second
   // pulse start (-1 = none) and length, delay_pending cycles, last_cause, count increment.
   typedef struct {
      int req_a; int len_a; int req_b; int off_b; int len_b; int mask;
      int dl_len; int den_len;
      int s1; int l1; int s2; int l2; int dp; int cause; int inc;
   } vec_t;

   vec_t vecs[13];
   vec_t por_v;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int s1, l1, s2, l2, nr, dp;
      logic prev;
      logic [NS-1:0] ra, rb;
      s1 = -1; l1 = 0; s2 = -1; l2 = 0; nr = 0; dp = 0; prev = 1'b0;
      for (int i = 0; i < RUN; i++) begin
         ra = (i < v.len_a) ? 4'(v.req_a) : 4'd0;
         rb = (i >= v.off_b && i < v.off_b + v.len_b) ? 4'(v.req_b) : 4'd0;
         req      = ra | rb;
         req_mask = 4'(v.mask);
         download = (i < v.dl_len);
         delay_en = (i < v.den_len);
         tick();
         if (core_reset && !prev) begin
            nr++;
            if (nr == 1) s1 = i;
            else if (nr == 2) s2 = i;
         end
         if (core_reset) begin
            if (nr == 1) l1++;
            else if (nr == 2) l2++;
         end
         if (delay_pending) dp++;
         prev = core_reset;
      end
      req = '0; req_mask = '0; download = 1'b0; delay_en = 1'b0;
      exp_count = (exp_count + v.inc > 255) ? 255 : exp_count + v.inc;
      chk({tag, "_start1"}, s1, v.s1);
      chk({tag, "_len1"}, l1, v.l1);
      chk({tag, "_start2"}, s2, v.s2);
      chk({tag, "_len2"}, l2, v.l2);
      chk({tag, "_dpend"}, dp, v.dp);
      chk({tag, "_cause"}, int'(last_cause), STATS ? v.cause : 0);
      chk({tag, "_count"}, int'(reset_count), STATS ? exp_count : 0);
   endtask

   task automatic pulse_once();
      req = 4'b0001;
      tick();
      req = '0;
      repeat (10) tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //             ra len rb off lb mask dl den  s1 l1  s2 l2 dp cause inc
      vecs[0]  = '{2, 1,  0, 0,  0, 0,   0, 0,   2, 8,  -1, 0, 0,  2,   1};
      vecs[1]  = '{1, 1,  4, 5,  1, 0,   0, 0,   2, 13, -1, 0, 0,  5,   1};
      vecs[2]  = '{4, 20, 0, 0,  0, 4,   0, 0,  -1, 0,  -1, 0, 0,  5,   0};
      vecs[3]  = '{8, 5,  0, 0,  0, 0,   0, 0,   2, 12, -1, 0, 0,  8,   1};
      vecs[4]  = '{3, 1,  0, 0,  0, 0,   0, 0,   2, 8,  -1, 0, 0,  3,   1};
      vecs[5]  = '{3, 1,  0, 0,  0, 1,   0, 0,   2, 8,  -1, 0, 0,  2,   1};
      vecs[6]  = '{15,10, 0, 0,  0, 15,  0, 0,  -1, 0,  -1, 0, 0,  2,   0};
      vecs[7]  = '{4, 1,  1, 8,  1, 0,   0, 0,   2, 16, -1, 0, 0,  5,   1};
      vecs[8]  = '{4, 1,  1, 9,  1, 0,   0, 0,   2, 8,  11, 8, 0,  1,   2};
      vecs[9]  = '{8, 5,  0, 0,  0, 0,   5, 5,   2, 12, 26, 8, 24, 16,  2};
      vecs[10] = '{8, 5,  0, 0,  0, 0,   5, 8,   2, 12, 26, 8, 24, 16,  2};
      vecs[11] = '{8, 5,  0, 0,  0, 0,   5, 3,   2, 12, -1, 0, 3,  8,   1};
      vecs[12] = '{8, 5,  1, 24, 1, 0,   5, 5,   2, 12, 26, 8, 24, 17,  2};
      por_v    = '{0, 0,  0, 0,  0, 0,   0, 0,   2, 8,  -1, 0, 0,  0,   1};

      reset = 1'b1; req = '0; req_mask = '0; download = 1'b0; delay_en = 1'b0;
      repeat (3) tick();
      chk("rst_core_reset", int'(core_reset), 0);
      chk("rst_delay_pending", int'(delay_pending), 0);
      chk("rst_last_cause", int'(last_cause), 0);
      chk("rst_reset_count", int'(reset_count), 0);

      reset = 1'b0;
      exp_count = 0;
      run_vec("por", por_v);

      for (int i = 0; i < 13; i++) begin
         run_vec($sformatf("v%0d", i), vecs[i]);
      end

      // Reset in the middle of a pulse with a delayed reset armed.
      download = 1'b1; delay_en = 1'b1; req = 4'b0001;
      tick();
      req = '0;
      repeat (3) tick();
      chk("mid_core_reset_before", int'(core_reset), 1);
      chk("mid_delay_pending_before", int'(delay_pending), 1);
      reset = 1'b1; download = 1'b0; delay_en = 1'b0;
      tick();
      chk("mid_core_reset", int'(core_reset), 0);
      chk("mid_delay_pending", int'(delay_pending), 0);
      chk("mid_last_cause", int'(last_cause), 0);
      chk("mid_reset_count", int'(reset_count), 0);
      tick();
      reset = 1'b0;
      exp_count = 0;
      run_vec("por2", por_v);

      // Saturation of the pulse counter.
      for (int p = 0; p < 253; p++) pulse_once();
      chk("sat_254", int'(reset_count), STATS ? 254 : 0);
      pulse_once();
      chk("sat_255", int'(reset_count), STATS ? 255 : 0);
      repeat (5) pulse_once();
      chk("sat_hold", int'(reset_count), STATS ? 255 : 0);
      chk("sat_idle", int'(core_reset), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
